// File: rtl/mem_arbiter.sv
// Shared data-memory arbiter: one transaction at a time, fixed priority Audio > SPART > CPU,
// with an aging guard that forces a CPU grant after CPU_MAX_WAIT consecutive non-CPU grants.
//
// state | meaning
// IDLE  | sample requests, latch the winner's command and owner code
// BUSY  | command strobed in first cycle, read data captured in last cycle
// DONE  | one-cycle ack to the owner
module mem_arbiter #(
  parameter int ADDR_W       = 16,
  parameter int DATA_W       = 32,
  parameter int MEM_LAT      = 2,
  parameter int CPU_MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              spart_req,
  input  logic              audio_req,
  input  logic              cpu_we,
  input  logic              spart_we,
  input  logic              audio_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [ADDR_W-1:0] spart_addr,
  input  logic [ADDR_W-1:0] audio_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic [DATA_W-1:0] spart_wdata,
  input  logic [DATA_W-1:0] audio_wdata,
  output logic              cpu_ack,
  output logic              spart_ack,
  output logic              audio_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic [DATA_W-1:0] spart_rdata,
  output logic [DATA_W-1:0] audio_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [1:0]        mem_busy
);

  localparam int LAT_W  = $clog2(MEM_LAT + 1);
  localparam int WAIT_W = $clog2(CPU_MAX_WAIT + 1);
  localparam logic [LAT_W-1:0]  LAT_LOAD = LAT_W'(MEM_LAT);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(CPU_MAX_WAIT);
  localparam logic [1:0] OWN_NONE  = 2'b00;
  localparam logic [1:0] OWN_CPU   = 2'b01;
  localparam logic [1:0] OWN_SPART = 2'b10;
  localparam logic [1:0] OWN_AUDIO = 2'b11;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t            state, state_nxt;
  logic [LAT_W-1:0]  lat_cnt;
  logic [WAIT_W-1:0] cpu_wait;
  logic [1:0]        owner;
  logic [1:0]        grant;
  logic              force_cpu;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  assign force_cpu = cpu_req && (cpu_wait == WAIT_MAX);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    grant     = OWN_NONE;
    mem_en    = 1'b0;
    mem_busy  = OWN_NONE;
    cpu_ack   = 1'b0;
    spart_ack = 1'b0;
    audio_ack = 1'b0;
    case (state)
      IDLE: begin
        if (force_cpu)      grant = OWN_CPU;
        else if (audio_req) grant = OWN_AUDIO;
        else if (spart_req) grant = OWN_SPART;
        else if (cpu_req)   grant = OWN_CPU;
        if (grant != OWN_NONE) state_nxt = BUSY;
      end
      BUSY: begin
        mem_busy = owner;
        mem_en   = (lat_cnt == LAT_LOAD);
        if (lat_cnt == '0) state_nxt = DONE;
      end
      DONE: begin
        mem_busy  = owner;
        cpu_ack   = (owner == OWN_CPU);
        spart_ack = (owner == OWN_SPART);
        audio_ack = (owner == OWN_AUDIO);
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    sel_we    = cpu_we;
    sel_addr  = cpu_addr;
    sel_wdata = cpu_wdata;
    case (grant)
      OWN_AUDIO: begin
        sel_we    = audio_we;
        sel_addr  = audio_addr;
        sel_wdata = audio_wdata;
      end
      OWN_SPART: begin
        sel_we    = spart_we;
        sel_addr  = spart_addr;
        sel_wdata = spart_wdata;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      owner       <= OWN_NONE;
      lat_cnt     <= '0;
      cpu_wait    <= '0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      cpu_rdata   <= '0;
      spart_rdata <= '0;
      audio_rdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          // Aging only counts losses suffered while the CPU is actually asking.
          if (!cpu_req || grant == OWN_CPU) cpu_wait <= '0;
          else if (grant != OWN_NONE && cpu_wait != WAIT_MAX) cpu_wait <= cpu_wait + 1'b1;
          if (grant != OWN_NONE) begin
            owner     <= grant;
            lat_cnt   <= LAT_LOAD;
            mem_we    <= sel_we;
            mem_addr  <= sel_addr;
            mem_wdata <= sel_wdata;
          end
        end
        BUSY: begin
          if (lat_cnt != '0) begin
            lat_cnt <= lat_cnt - 1'b1;
          end else if (!mem_we) begin
            case (owner)
              OWN_CPU:   cpu_rdata   <= mem_rdata;
              OWN_SPART: spart_rdata <= mem_rdata;
              OWN_AUDIO: audio_rdata <= mem_rdata;
              default: ;
            endcase
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Arbitrates the single-port shared data memory between three requesters: the CPU MEM stage, the SPART interface, and the Audio interface. It serializes one transaction at a time and drives the memory port. It reports the current owner on `mem_busy`, which the hazard/control logic uses to stall the pipeline. Priority is fixed at Audio > SPART > CPU, with an aging guard that keeps the CPU from being starved.

## Interface
Parameters:
- `ADDR_W`, default 16: memory address width.
- `DATA_W`, default 32: memory data width.
- `MEM_LAT`, default 2: cycles from `mem_en` to a valid `mem_rdata`. Must be ≥1.
- `CPU_MAX_WAIT`, default 4: number of consecutive non-CPU grants while `cpu_req` is pending before the CPU is forced next. Must be ≥1.

Ports (synchronous, active-high reset; single clock):
- `clk` in 1: clock. All logic is on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `cpu_req`, `spart_req`, `audio_req` in 1 each: transaction request. Hold high with stable fields until ack.
- `cpu_we`, `spart_we`, `audio_we` in 1 each: 1 = write, 0 = read.
- `cpu_addr`, `spart_addr`, `audio_addr` in ADDR_W each: transaction address.
- `cpu_wdata`, `spart_wdata`, `audio_wdata` in DATA_W each: write data.
- `cpu_ack`, `spart_ack`, `audio_ack` out 1 each: one-cycle pulse when the transaction completes.
- `cpu_rdata`, `spart_rdata`, `audio_rdata` out DATA_W each: read data. Registered, and valid in the ack cycle. Each holds its value until that requester's next read.
- `mem_en` out 1: one-cycle command strobe to memory.
- `mem_we`, `mem_addr`, `mem_wdata` out 1 / ADDR_W / DATA_W: command fields. Valid when `mem_en`=1, and held for the whole transaction.
- `mem_rdata` in DATA_W: memory read data. Valid exactly MEM_LAT cycles after `mem_en`.
- `mem_busy` out 2: current owner. 00 = idle, 01 = CPU, 10 = SPART, 11 = Audio.

## Operation
States:
- IDLE: samples the requests.
  - If any request is present: latch the winner's `we`/`addr`/`wdata` and its owner code, then go to BUSY.
  - Otherwise stay in IDLE.
- BUSY: lasts MEM_LAT+1 cycles.
  - `mem_en`=1 in the first BUSY cycle only.
  - On the last BUSY cycle, `mem_rdata` is registered into the owner's rdata if the transaction is a read. Then go to DONE.
- DONE: lasts one cycle.
  - The owner's ack=1.
  - Go to IDLE.

Arbitration (evaluated in IDLE only):
- Normal order is Audio, then SPART, then CPU.
- Forced CPU: if `cpu_req`=1 and `cpu_wait`==CPU_MAX_WAIT, grant the CPU regardless of the other requests.

`cpu_wait` counter:
- Increments on each Audio or SPART grant made while `cpu_req`=1. It saturates at CPU_MAX_WAIT.
- Clears on a CPU grant.
- Clears when IDLE sees `cpu_req`=0.

Output behaviour:
- `mem_busy` equals the owner code throughout BUSY and DONE, and is 00 in IDLE.
- Writes: no rdata register changes. The ack timing is identical to a read.
- No requester receives an ack without a grant. Ack is never asserted for two requesters in the same cycle.

Request handling:
- A request that is still high in the IDLE cycle after its ack counts as a new transaction.
- A requester must drop `req` at the edge that ends its ack cycle if it has nothing further to issue.

Reset:
- `rst`=1 forces IDLE and clears `cpu_wait`.
- All acks, `mem_en`, `mem_we` and `mem_busy` go to 0.
- `mem_addr`, `mem_wdata` and all rdata registers go to 0.
- Reset mid-transaction abandons the transaction: no ack, and a late `mem_rdata` is ignored. The requester must reissue.

## Timing
- Request sampled in IDLE at cycle t.
- `mem_en` at t+1.
- `mem_rdata` valid at t+1+MEM_LAT and captured at the end of that cycle.
- Ack and valid rdata at t+2+MEM_LAT. Request-to-ack latency is MEM_LAT+2 cycles.
- `mem_busy`≠00 from t+1 through t+2+MEM_LAT.
- Back-to-back issue rate for one requester holding `req`: one transaction per MEM_LAT+3 cycles. The next IDLE sample is at t+3+MEM_LAT.
- A request that arrives during BUSY or DONE waits for IDLE. A request is never lost while held.
- Simultaneous requests are resolved in the same IDLE cycle. Losers are served in subsequent IDLE cycles.

## Test plan
1. **CPU read.** CPU reads 0x0010 at t; memory returns 0xDEADBEEF at t+3 (MEM_LAT=2).
   - Required: `mem_en`=1 with addr 0x0010 at t+1 only.
   - Required: `cpu_ack`=1 at t+4 with `cpu_rdata`=0xDEADBEEF.
   - Required: `mem_busy`=01 at t+1..t+4, and 00 at t+5.
2. **Simultaneous requests.** All three raise `req` at t, each drops after its own ack.
   - Required grant order: Audio (`mem_busy`=11, ack t+4), then SPART (ack t+9), then CPU (ack t+14).
3. **Starvation guard.** Audio and SPART request continuously; CPU requests at t.
   - Required: exactly 4 non-CPU grants, then the CPU is granted on the 5th IDLE sample.
   - Required: `cpu_wait` clears after the CPU grant.
4. **SPART write.** SPART writes 0x00001234 to 0x0040.
   - Required: `mem_en`=`mem_we`=1 with those fields at t+1.
   - Required: `spart_ack` at t+4, and `spart_rdata` unchanged from its previous value.
5. **Reset mid-transaction.** `rst`=1 at t+2 during a CPU read.
   - Required at t+3: all outputs 0 and state IDLE.
   - Required: no `cpu_ack`, and the memory's t+3 data is not captured.
   - Required: a reissued request completes normally with MEM_LAT+2 latency.
6. **Back-to-back CPU reads.** CPU holds `req` for two reads.
   - Required: `mem_en` pulses at t+1 and t+6.
   - Required: `cpu_ack` pulses at t+4 and t+9.
